// File: rtl/hex_scan_display_driver.sv
// hex_scan_display_driver
//   Takes a 32-bit debug word as 8 hex nibbles and drives one time-multiplexed
//   7-segment bank. Each digit slot lasts SCAN_DIV clocks. The first cycle of
//   every slot is dark to suppress ghosting while the anode switches.
//
// Parameters
//   SCAN_DIV    clocks per digit slot, including the dark cycle (2..2^20)
//   PRESCALE_W  prescaler width; 2^PRESCALE_W must be >= SCAN_DIV
//
// Ports
//   Clock         in   1  rising-edge system clock
//   Resetn        in   1  asynchronous active-low reset
//   Data_In       in  32  word to display; nibble k -> digit k (digit 0 rightmost)
//   Data_Valid    in   1  load strobe for Data_In
//   Freeze        in   1  1 = drop loads and hold the current snapshot
//   Blank         in   1  1 = all digits dark; scanning keeps running
//   Seg_Out       out  7  active-low segments {g,f,e,d,c,b,a}
//   Digit_En      out  8  active-low one-hot digit enables
//   Scan_Tick     out  1  high on the last cycle of each digit slot
//   Snapshot_Out  out 32  current snapshot register
//
// Optional build macro
//   HEX_LEADING_ZERO_BLANK_EN  when defined, digit k (k>=1) stays dark if
//                              snapshot nibbles k..7 are all zero.
module hex_scan_display_driver #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned PRESCALE_W = 20
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [31:0] Data_In,
  input  logic        Data_Valid,
  input  logic        Freeze,
  input  logic        Blank,
  output logic [6:0]  Seg_Out,
  output logic [7:0]  Digit_En,
  output logic        Scan_Tick,
  output logic [31:0] Snapshot_Out
);

  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(SCAN_DIV - 1);

  logic [31:0]           snapshot_q, snapshot_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [2:0]            idx_q, idx_d;
  logic                  slot_end;

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign slot_end = (presc_q == PRESC_LAST);

  always_comb begin
    snapshot_d = snapshot_q;
    // Loads are applied immediately, even mid-slot; while frozen they are lost.
    if (Data_Valid && !Freeze) begin
      snapshot_d = Data_In;
    end
    presc_d = slot_end ? '0 : presc_q + 1'b1;
    idx_d   = slot_end ? idx_q + 3'd1 : idx_q;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      snapshot_q <= '0;
      presc_q    <= '0;
      idx_q      <= '0;
    end else begin
      snapshot_q <= snapshot_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
    end
  end

  // Per-digit nibble split and visibility.
  logic [3:0] nibble [8];
  logic [7:0] digit_shown;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      assign nibble[gi] = snapshot_q[4*gi +: 4];
`ifdef HEX_LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_lsd
        // Rightmost digit is always lit so a zero word still reads "0".
        assign digit_shown[gi] = 1'b1;
      end else begin : g_upper
        assign digit_shown[gi] = |snapshot_q[31:4*gi];
      end
`else
      assign digit_shown[gi] = 1'b1;
`endif
    end
  endgenerate

  logic       digit_active;
  logic [3:0] nibble_sel;

  assign nibble_sel = nibble[idx_q];

  // Dark on the first cycle of each slot (ghost blanking), when Blank is
  // asserted, or when the digit is suppressed as a leading zero.
  assign digit_active = (presc_q != '0) && !Blank && digit_shown[idx_q];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_anode
      assign Digit_En[gi] = !(digit_active && (idx_q == 3'(gi)));
    end
  endgenerate

  assign Seg_Out      = digit_active ? hex_to_seg(nibble_sel) : 7'h7F;
  assign Scan_Tick    = slot_end;
  assign Snapshot_Out = snapshot_q;

endmodule

// File: tb/tb_hex_scan_display_driver.sv
// Directed bench for hex_scan_display_driver with SCAN_DIV=4.
// A vector table covers reset release and the first slots; hand sequences
// cover scanning, freeze, blank, asynchronous reset and leading-zero blanking.
module tb_hex_scan_display_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din;
  logic        dv, frz, blank;
  logic [6:0]  seg;
  logic [7:0]  en;
  logic        tick;
  logic [31:0] snap;

  int passed = 0;
  int total  = 0;

  // Scan position and snapshot as the bench expects them to be.
  int          presc_m;
  logic [2:0]  idx_m;
  logic [31:0] snap_m;

  // Decode table written out by hand, active-low gfedcba.
  logic [6:0] dec_tab [16];

  hex_scan_display_driver #(.SCAN_DIV(4), .PRESCALE_W(4)) dut (
    .Clock(clk), .Resetn(rst_n), .Data_In(din), .Data_Valid(dv),
    .Freeze(frz), .Blank(blank), .Seg_Out(seg), .Digit_En(en),
    .Scan_Tick(tick), .Snapshot_Out(snap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [31:0] din;
    logic        blank;
    logic [7:0]  en;
    logic [6:0]  seg;
    logic        tick;
    logic [31:0] snap;
  } vec_t;

  vec_t vecs [12];

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) $display("FAIL %s: got %h, want %h", name, got, want);
    else passed++;
  endtask

  function automatic logic shown_m();
`ifdef HEX_LEADING_ZERO_BLANK_EN
    return (idx_m == 3'd0) || ((snap_m >> (4 * int'(idx_m))) != 32'h0);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [7:0] en_m();
    if (blank || presc_m == 0 || !shown_m()) return 8'hFF;
    return ~(8'h01 << idx_m);
  endfunction

  function automatic logic [6:0] seg_m();
    logic [3:0] nib;
    if (blank || presc_m == 0 || !shown_m()) return 7'h7F;
    nib = snap_m[4*idx_m +: 4];
    return dec_tab[nib];
  endfunction

  // Advance one clock: apply the expected effect of the current inputs, then
  // wait to the next falling edge.
  task automatic step();
    if (dv && !frz) snap_m = din;
    if (presc_m == 3) begin
      presc_m = 0;
      idx_m   = idx_m + 3'd1;
    end else begin
      presc_m = presc_m + 1;
    end
    @(negedge clk);
  endtask

  task automatic check_scan(input string name);
    #1;
    cmp({name, "_en"},   {24'h0, en},   {24'h0, en_m()});
    cmp({name, "_seg"},  {25'h0, seg},  {25'h0, seg_m()});
    cmp({name, "_tick"}, {31'h0, tick}, {31'h0, (presc_m == 3)});
    cmp({name, "_snap"}, snap, snap_m);
    $display("%s: idx=%0d presc=%0d en=%h seg=%h tick=%b snap=%h",
             name, idx_m, presc_m, en, seg, tick, snap);
  endtask

  initial begin
    dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Cycle n = state after n rising edges from reset release.
    vecs[0]  = '{1'b0, 32'h0,        1'b0, 8'hFF, 7'h7F, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, 8'hFE, 7'h40, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 8'hFE, 7'h40, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0,        1'b0, 8'hFE, 7'h40, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 32'h0,        1'b0, 8'hFF, 7'h7F, 1'b0, 32'h0};
`ifdef HEX_LEADING_ZERO_BLANK_EN
    vecs[5]  = '{1'b0, 32'h0,        1'b0, 8'hFF, 7'h7F, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 8'hFF, 7'h7F, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0,        1'b0, 8'hFF, 7'h7F, 1'b1, 32'h0};
`else
    vecs[5]  = '{1'b0, 32'h0,        1'b0, 8'hFD, 7'h40, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 8'hFD, 7'h40, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0,        1'b0, 8'hFD, 7'h40, 1'b1, 32'h0};
`endif
    // Load at the slot start of digit 2; next cycle shows nibble B.
    vecs[8]  = '{1'b1, 32'h0123ABCD, 1'b0, 8'hFF, 7'h7F, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0,        1'b0, 8'hFB, 7'h03, 1'b0, 32'h0123ABCD};
    vecs[10] = '{1'b0, 32'h0,        1'b1, 8'hFF, 7'h7F, 1'b0, 32'h0123ABCD};
    vecs[11] = '{1'b0, 32'h0,        1'b0, 8'hFB, 7'h03, 1'b1, 32'h0123ABCD};

    rst_n = 1'b0; din = '0; dv = 1'b0; frz = 1'b0; blank = 1'b0;
    #1;
    cmp("rst_en",   {24'h0, en},   32'hFF);
    cmp("rst_seg",  {25'h0, seg},  32'h7F);
    cmp("rst_tick", {31'h0, tick}, 32'h0);
    cmp("rst_snap", snap,          32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      dv = vecs[i].dv; din = vecs[i].din; blank = vecs[i].blank;
      #1;
      cmp($sformatf("vec%0d_en", i),   {24'h0, en},   {24'h0, vecs[i].en});
      cmp($sformatf("vec%0d_seg", i),  {25'h0, seg},  {25'h0, vecs[i].seg});
      cmp($sformatf("vec%0d_tick", i), {31'h0, tick}, {31'h0, vecs[i].tick});
      cmp($sformatf("vec%0d_snap", i), snap,          vecs[i].snap);
      $display("vec %0d: en=%h seg=%h tick=%b snap=%h", i, en, seg, tick, snap);
      @(negedge clk);
    end
    dv = 1'b0; din = '0; blank = 1'b0;

    // Cycle 12: slot start of digit 3.
    presc_m = 0; idx_m = 3'd3; snap_m = 32'h0123ABCD;

    // 32 cycles across digits 3..7, wrap 7->0, then 0..2.
    for (int c = 0; c < 32; c++) begin
      check_scan($sformatf("scan%0d", c));
      step();
    end

    // Load, then a frozen load that must be dropped and not replayed.
    dv = 1'b1; din = 32'hDEADBEEF; step(); dv = 1'b0;
    check_scan("load_dead");
    frz = 1'b1; dv = 1'b1; din = 32'h11111111; step(); dv = 1'b0;
    check_scan("frozen");
    frz = 1'b0; step();
    check_scan("unfrozen1");
    step();
    check_scan("unfrozen2");

    // Data_Valid held high tracks Data_In every cycle.
    dv = 1'b1; din = 32'h89ABCDEF; step();
    check_scan("track1");
    din = 32'h76543210; step();
    check_scan("track2");
    dv = 1'b0; din = '0;

    // Blank for 12 cycles from a slot start; index still advances 3 slots.
    for (int k = 0; k < 8 && presc_m != 0; k++) step();
    blank = 1'b1;
    for (int c = 0; c < 12; c++) begin
      check_scan($sformatf("blank%0d", c));
      step();
    end
    blank = 1'b0;
    step();
    check_scan("unblank");

    // Asynchronous reset mid-slot at digit 5.
    dv = 1'b1; din = 32'hFFFFFFFF; step(); dv = 1'b0; din = '0;
    for (int k = 0; k < 64 && !(idx_m == 3'd5 && presc_m == 2); k++) step();
    check_scan("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_en",   {24'h0, en},   32'hFF);
    cmp("arst_seg",  {25'h0, seg},  32'h7F);
    cmp("arst_tick", {31'h0, tick}, 32'h0);
    cmp("arst_snap", snap,          32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    presc_m = 0; idx_m = 3'd0; snap_m = 32'h0;
    check_scan("post_rst0");
    step();
    check_scan("post_rst1");

    // Leading-zero behaviour (all digits shown in the default build).
    dv = 1'b1; din = 32'h000000A0; step(); dv = 1'b0; din = '0;
    for (int k = 0; k < 8 && presc_m != 0; k++) step();
    for (int c = 0; c < 32; c++) begin
      check_scan($sformatf("lz_a0_%0d", c));
      step();
    end
    dv = 1'b1; din = 32'h0; step(); dv = 1'b0;
    for (int c = 0; c < 32; c++) begin
      check_scan($sformatf("lz_zero_%0d", c));
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
